// File: rtl/prog_loader.sv
// Byte-stream program loader: parses a count header and 9-bit words into instruction-memory writes.
// Optional LOADER_CHKSUM_EN adds a trailing XOR checksum byte and the error path.
module prog_loader #(
   parameter int D = 12
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         in_valid,
   input  logic [7:0]   in_data,
   output logic         in_ready,
   output logic         wr_en,
   output logic [D-1:0] wr_addr,
   output logic [8:0]   wr_data,
   output logic         cpu_hold,
   output logic         load_done,
   output logic         err
);

   typedef enum logic [2:0] {
      S_HDR_LO,
      S_HDR_HI,
      S_W_LO,
      S_W_HI,
`ifdef LOADER_CHKSUM_EN
      S_CHK,
`endif
      S_DONE,
      S_ERR
   } state_t;

   state_t         state, state_nxt, end_state;
   logic           accept;
   logic [7:0]     lo_byte;
   logic [11:0]    count;
   logic [D-1:0]   addr;
   logic [11:0]    hdr_count;

`ifdef LOADER_CHKSUM_EN
   logic [7:0]     chk;
`endif

   assign hdr_count = {in_data[3:0], lo_byte};

   always_comb begin
      in_ready  = 1'b0;
      cpu_hold  = 1'b1;
      load_done = 1'b0;
      err       = 1'b0;
      state_nxt = state;
`ifdef LOADER_CHKSUM_EN
      end_state = S_CHK;
`else
      end_state = S_DONE;
`endif

      case (state)
         S_HDR_LO, S_HDR_HI, S_W_LO, S_W_HI: in_ready = 1'b1;
`ifdef LOADER_CHKSUM_EN
         S_CHK:  in_ready = 1'b1;
         S_ERR:  err      = 1'b1;
`endif
         S_DONE: begin
            cpu_hold  = 1'b0;
            load_done = 1'b1;
         end
         default: ;
      endcase

      accept = in_valid && in_ready;

      case (state)
         S_HDR_LO: if (accept) state_nxt = S_HDR_HI;
         S_HDR_HI: if (accept) state_nxt = (hdr_count != 12'd0) ? S_W_LO : end_state;
         S_W_LO:   if (accept) state_nxt = S_W_HI;
         S_W_HI:   if (accept) state_nxt = (count != 12'd1) ? S_W_LO : end_state;
`ifdef LOADER_CHKSUM_EN
         S_CHK:    if (accept) state_nxt = (in_data == chk) ? S_DONE : S_ERR;
`endif
         S_DONE, S_ERR: if (start) state_nxt = S_HDR_LO;
         default:  state_nxt = S_HDR_LO;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_HDR_LO;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lo_byte <= '0;
         count   <= '0;
         addr    <= '0;
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
      end else begin
         wr_en <= 1'b0;
         if (accept) begin
            case (state)
               S_HDR_LO: lo_byte <= in_data;
               S_HDR_HI: begin
                  count <= hdr_count;
                  addr  <= '0;
               end
               S_W_LO:   lo_byte <= in_data;
               S_W_HI: begin
                  wr_en   <= 1'b1;
                  wr_addr <= addr;
                  wr_data <= {in_data[0], lo_byte};
                  addr    <= addr + 1'b1;
                  count   <= count - 12'd1;
               end
               default: ;
            endcase
         end
      end
   end

`ifdef LOADER_CHKSUM_EN
   // The checksum byte itself is not folded into the accumulator.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         chk <= '0;
      else if ((state == S_DONE || state == S_ERR) && start)
         chk <= '0;
      else if (accept && state != S_CHK)
         chk <= chk ^ in_data;
   end
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader; the reference model encodes word lists into
// byte streams and predicts the write sequence and final status (honours LOADER_CHKSUM_EN).
module tb_prog_loader;

   localparam int D = 12;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic         in_valid;
   logic [7:0]   in_data;
   logic         in_ready;
   logic         wr_en;
   logic [D-1:0] wr_addr;
   logic [8:0]   wr_data;
   logic         cpu_hold;
   logic         load_done;
   logic         err;

   int n_checks = 0;
   int n_fail   = 0;

   int          exp_addr[$];
   int          exp_data[$];
   int          last_addr = 0;
   int          last_data = 0;
   logic [8:0]  prog[$];

   prog_loader #(.D(D)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .cpu_hold  (cpu_hold),
      .load_done (load_done),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Write monitor: every strobe must match the next predicted write; outputs hold otherwise.
   always @(negedge clk) begin
      if (reset) begin
         if (wr_en) begin
            if (exp_addr.size() == 0) begin
               check("extra_wr", wr_en, 1'b0);
            end else begin
               last_addr = exp_addr.pop_front();
               last_data = exp_data.pop_front();
               check("wr_addr", wr_addr, last_addr);
               check("wr_data", wr_data, last_data);
            end
         end else begin
            check("hold_addr", wr_addr, last_addr);
            check("hold_data", wr_data, last_data);
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int n;
      if (gaps) begin
         repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            start    = ($urandom_range(0, 3) == 0);
         end
      end
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = b;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("accept_bound", in_ready, 1'b1);
      @(posedge clk);
   endtask

   task automatic start_pulse();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("st_ready", in_ready, 1'b1);
      check("st_done", load_done, 1'b0);
      check("st_err", err, 1'b0);
      check("st_hold", cpu_hold, 1'b1);
   endtask

   task automatic load(input bit gaps, input bit junk, input bit good);
      logic [7:0]  bytes[$];
      logic [7:0]  sum;
      logic [11:0] cnt;
      bit          ok;
      cnt = 12'(prog.size());
      bytes.push_back(cnt[7:0]);
      bytes.push_back({junk ? 4'($urandom) : 4'h0, cnt[11:8]});
      foreach (prog[i]) begin
         bytes.push_back(prog[i][7:0]);
         bytes.push_back({junk ? 7'($urandom) : 7'h0, prog[i][8]});
         exp_addr.push_back(i);
         exp_data.push_back(int'(prog[i]));
      end
      sum = 8'h00;
      foreach (bytes[i]) sum ^= bytes[i];
`ifdef LOADER_CHKSUM_EN
      bytes.push_back(good ? sum : (sum ^ 8'h5A));
      ok = good;
`else
      ok = 1'b1;
`endif
      foreach (bytes[i]) send_byte(bytes[i], gaps);
      @(negedge clk);
      in_valid = 1'b0;
      check("end_done", load_done, ok);
      check("end_err", err, !ok);
      check("end_hold", cpu_hold, !ok);
      check("end_ready", in_ready, 1'b0);
      repeat (2) @(negedge clk);
      check("writes_left", exp_addr.size(), 0);
   endtask

   task automatic rand_prog(input int n);
      prog.delete();
      for (int i = 0; i < n; i++) prog.push_back(9'($urandom));
   endtask

   initial begin
      logic [7:0] cb;
      reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      #3;
      check("rst_ready", in_ready, 1'b1);
      check("rst_wr_en", wr_en, 1'b0);
      check("rst_addr", wr_addr, 0);
      check("rst_data", wr_data, 0);
      check("rst_hold", cpu_hold, 1'b1);
      check("rst_done", load_done, 1'b0);
      check("rst_err", err, 1'b0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // Stream 02,00,34,01,FF,00 straight after reset, no start.
      prog = '{9'h134, 9'h0FF};
      load(1'b0, 1'b0, 1'b1);

      start_pulse();
      prog.delete();
      load(1'b0, 1'b0, 1'b1);

      // start and a byte together in DONE: start wins, byte dropped.
      @(negedge clk);
      start = 1'b1; in_valid = 1'b1; in_data = 8'h05;
      check("race_ready", in_ready, 1'b0);
      @(negedge clk);
      start = 1'b0; in_valid = 1'b0;
      check("race_ready2", in_ready, 1'b1);
      check("race_done", load_done, 1'b0);
      rand_prog(1);
      load(1'b0, 1'b0, 1'b1);

      start_pulse();
      rand_prog(4);
      load(1'b1, 1'b1, 1'b1);

      for (int k = 0; k < 6; k++) begin
         start_pulse();
         rand_prog($urandom_range(1, 20));
         load(1'b1, 1'b1, 1'b1);
      end

`ifdef LOADER_CHKSUM_EN
      start_pulse();
      prog = '{9'h1AA};
      load(1'b0, 1'b0, 1'b1);
      start_pulse();
      load(1'b0, 1'b0, 1'b0);
      start_pulse();
`endif

      // Reset between low and high bytes of word 1.
      start_pulse();
      send_byte(8'h03, 1'b0);
      send_byte(8'h00, 1'b0);
      exp_addr.push_back(0);
      exp_data.push_back(9'h1C3);
      send_byte(8'hC3, 1'b0);
      send_byte(8'h01, 1'b0);
      send_byte(8'h11, 1'b0);
      #2;
      reset = 1'b0;
      in_valid = 1'b0;
      last_addr = 0;
      last_data = 0;
      #1;
      check("mid_wr_en", wr_en, 1'b0);
      check("mid_addr", wr_addr, 0);
      check("mid_data", wr_data, 0);
      check("mid_hold", cpu_hold, 1'b1);
      check("mid_done", load_done, 1'b0);
      check("mid_err", err, 1'b0);
      check("mid_ready", in_ready, 1'b1);
      check("mid_w0", exp_addr.size(), 0);
      exp_addr.delete();
      exp_data.delete();
      @(negedge clk);
      reset = 1'b1;
      rand_prog(5);
      load(1'b1, 1'b0, 1'b1);

      cb = 8'h00;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + int'(cb));
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter D, default 12, instruction-memory address width; it SHALL match the program counter width.
REQ-002 Port clk  input  1  the only clock; all state SHALL update on its rising edge.
REQ-003 Port reset  input  1  asynchronous, active-low reset.
REQ-004 Port start  input  1  single-cycle request to begin a new load; honoured only in DONE or ERR.
REQ-005 Port in_valid  input  1  in_data holds a byte.
REQ-006 Port in_data  input  8  stream byte.
REQ-007 Port in_ready  output  1  loader can take a byte; a byte is accepted when in_valid and in_ready are both high at a rising edge.
REQ-008 Port wr_en  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 Port wr_addr  output  D  instruction-memory write address.
REQ-010 Port wr_data  output  9  machine-code word.
REQ-011 Port cpu_hold  output  1  holds the CPU in reset while a load is in progress.
REQ-012 Port load_done  output  1  the last load finished cleanly.
REQ-013 Port err  output  1  the last load aborted; sticky until start or reset.

Function
REQ-014 Stream format: HDR_LO byte = count[7:0]; HDR_HI byte = count[11:8] in bits 3:0, bits 7:4 ignored; then count words, each sent as a low byte (word[7:0]) followed by a high byte (bit0 = word[8], bits 7:1 ignored).
REQ-015 FSM states SHALL be S_HDR_LO, S_HDR_HI, S_W_LO, S_W_HI, S_CHK (macro only), S_DONE, S_ERR.
REQ-016 in_ready SHALL be 1 in S_HDR_LO, S_HDR_HI, S_W_LO, S_W_HI and S_CHK, and 0 in S_DONE and S_ERR.
REQ-017 Each transition SHALL occur only on an accepted byte; the FSM SHALL hold its state while in_valid is low.
REQ-018 Accepting the S_HDR_HI byte SHALL load the 12-bit word counter and clear the address to 0.
  - Counter != 0: next state S_W_LO.
  - Counter == 0: next state S_CHK if the macro is defined, else S_DONE.
REQ-019 Accepting the S_W_LO byte SHALL latch word[7:0] and move to S_W_HI.
REQ-020 Accepting the S_W_HI byte SHALL register wr_data and wr_addr (the current address), so that wr_en is high for exactly the following cycle.
  - Address increments by 1; counter decrements by 1.
  - Next state: S_W_LO if words remain; otherwise S_CHK (macro) or S_DONE.
REQ-021 wr_addr SHALL increase by one per word starting at 0; it SHALL NOT wrap, since count <= 4095 < 2^D when D = 12.
REQ-022 wr_data and wr_addr SHALL hold their values whenever wr_en is low.
REQ-023 cpu_hold SHALL be 1 in every state except S_DONE.
  - load_done = 1 only in S_DONE; err = 1 only in S_ERR.
REQ-024 start in S_DONE or S_ERR SHALL move the FSM to S_HDR_LO and clear load_done and err; start in any other state SHALL be ignored.
REQ-025 If start and in_valid are both high in S_DONE, start SHALL win and no byte is accepted, because in_ready = 0.
REQ-026 No input byte SHALL ever be dropped or duplicated; each accepted byte SHALL advance the FSM by exactly one step.

Reset
REQ-027 reset low SHALL immediately force the following, independent of clk and including mid-load:
  - state S_HDR_LO;
  - wr_en = 0, wr_addr = 0, wr_data = 0;
  - counter = 0;
  - cpu_hold = 1, load_done = 0, err = 0;
  - checksum register = 0.
REQ-028 After reset is released, the loader SHALL be ready (in_ready = 1) on the first clock edge, with no start required.

Configuration
REQ-029 Macro LOADER_CHKSUM_EN, when defined:
  - an 8-bit register accumulates the XOR of every accepted header and word byte;
  - S_CHK accepts one byte; if it equals the accumulator, next state is S_DONE, otherwise S_ERR;
  - the accumulator clears on reset and on start.
REQ-030 Without LOADER_CHKSUM_EN:
  - S_CHK and the accumulator SHALL NOT exist;
  - err SHALL be tied to 0;
  - S_ERR SHALL be unreachable.

Verification
REQ-031 Stream 02,00,34,01,FF,00 (no macro) -> wr_en pulses with (addr 0, data 0x134) and then (addr 1, data 0x0FF); the cycle after the last byte, load_done = 1 and cpu_hold = 0.
REQ-032 Stream 00,00 -> no wr_en pulse; S_DONE is reached directly without the macro, or after checksum byte 00 with the macro.
REQ-033 Macro defined, stream 01,00,AA,01 then checksum AA -> load_done = 1; the same stream with checksum AB -> err = 1, cpu_hold = 1, in_ready = 0.
REQ-034 reset driven low between the low and high bytes of word 1 -> outputs return to their reset values asynchronously; a fresh stream then loads correctly from addr 0.
REQ-035 in_valid toggled randomly on a 4-word load -> wr_addr sequence is exactly 0,1,2,3 with no extra wr_en; start pulsed mid-load -> ignored.
REQ-036 In S_DONE, drive start and in_valid together with in_data 05 -> byte not accepted; the next accepted byte is treated as HDR_LO.
